link_channel_tx: RTL

- Transmit endpoint of the inter-FPGA channel link between two decoder partitions.
- Collects CHANNELS independent valid/ready message streams and the per-channel status flags (message-flying, odd-clusters).
- Multiplexes them onto one framed link with channel tags, using round-robin arbitration and periodic/on-change status frames.
- The matching receive endpoint demultiplexes frames back into per-channel streams and status flags.

---
 rtl/link_channel_tx.sv | 113 +++++++++++
 1 files changed

// File: rtl/link_channel_tx.sv
// link_channel_tx: transmit end of the inter-FPGA channel link.
// Muxes one-entry per-channel buffers and status frames onto a single framed link.
module link_channel_tx #(
   parameter int unsigned WIDTH         = 128,
   parameter int unsigned CHANNELS      = 4,
   parameter int unsigned STATUS_PERIOD = 16,
   localparam int unsigned CW           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int unsigned LINK_WIDTH   = WIDTH + CW + 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [WIDTH*CHANNELS-1:0]    in_data,
   input  logic [CHANNELS-1:0]          in_valid,
   output logic [CHANNELS-1:0]          in_ready,
   input  logic [CHANNELS-1:0]          has_message_flying,
   input  logic [CHANNELS-1:0]          has_odd_clusters,
   output logic [LINK_WIDTH-1:0]        link_data,
   output logic                         link_valid,
   input  logic                         link_ready
);

   localparam int unsigned CNTW = $clog2(STATUS_PERIOD);
   localparam logic [CNTW-1:0] CNT_MAX = CNTW'(STATUS_PERIOD - 1);
   localparam int unsigned SW = 2 * CHANNELS;

   typedef enum logic {FRAME_DATA = 1'b0, FRAME_STATUS = 1'b1} frame_t;

   logic [CHANNELS-1:0]   full_q, full_d, capture;
   logic [WIDTH-1:0]      buf_q [CHANNELS];
   logic [CW-1:0]         ptr_q, ptr_d, grant, idx;
   logic                  found;
   logic [SW-1:0]         status_now, snap_q, snap_d;
   logic [CNTW-1:0]       cnt_q, cnt_d;
   logic                  pending_q, pending_d, pend_eff;
   logic                  load_en, load_status, load_data;
   logic                  valid_d;
   logic [LINK_WIDTH-1:0] data_d;

   always_comb begin
      capture    = in_valid & in_ready;
      status_now = {has_odd_clusters, has_message_flying};
      load_en    = ~link_valid | link_ready;
      // A status change or period expiry takes effect in the same cycle it is seen
      pend_eff   = pending_q | (status_now != snap_q) | (cnt_q == CNT_MAX);

      found = 1'b0;
      grant = ptr_q;
      idx   = '0;
      for (int unsigned k = 1; k <= CHANNELS; k++) begin
         idx = CW'((32'(ptr_q) + k) % CHANNELS);
         if (!found && full_q[idx]) begin
            found = 1'b1;
            grant = idx;
         end
      end

      load_status = load_en & pend_eff;
      load_data   = load_en & ~pend_eff & found;

      valid_d   = 1'b0;
      data_d    = link_data;
      ptr_d     = ptr_q;
      full_d    = full_q;
      pending_d = pend_eff;
      snap_d    = snap_q;
      cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNTW'(1);

      if (load_status) begin
         valid_d   = 1'b1;
         data_d    = {FRAME_STATUS, {CW{1'b0}}, WIDTH'(status_now)};
         pending_d = 1'b0;
         snap_d    = status_now;
         cnt_d     = '0;
      end else if (load_data) begin
         valid_d       = 1'b1;
         data_d        = {FRAME_DATA, grant, buf_q[grant]};
         ptr_d         = grant;
         full_d[grant] = 1'b0;
      end
      full_d = full_d | capture;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         full_q     <= '0;
         in_ready   <= '0;
         link_valid <= 1'b0;
         link_data  <= '0;
         ptr_q      <= CW'(CHANNELS - 1);
         snap_q     <= '0;
         cnt_q      <= '0;
         pending_q  <= 1'b1;
      end else begin
         full_q    <= full_d;
         in_ready  <= ~full_d;
         ptr_q     <= ptr_d;
         snap_q    <= snap_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         if (load_en) begin
            link_valid <= valid_d;
            link_data  <= data_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (capture[i]) buf_q[i] <= in_data[i*WIDTH +: WIDTH];
      end
   end

endmodule
